ultrasonic_sensor_trigger: RTL and testbench

ULTRASONIC_SENSOR_TRIGGER -- requirements
Module: ultrasonic_sensor_trigger

---
 rtl/ultrasonic_sensor_trigger.sv | 144 ++++++++++++++
 tb/tb_ultrasonic_sensor_trigger.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_sensor_trigger.sv
// Trigger/echo sequencer for an ultrasonic range sensor: fires a fixed-width trigger,
// waits for a complete echo pulse within a time limit, then holds off until the period ends.
module ultrasonic_sensor_trigger #(
  parameter int TRIG_CYCLES_P    = 500,
  parameter int TIMEOUT_CYCLES_P = 1900000,
  parameter int PERIOD_CYCLES_P  = 3000000
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic Start_i,
  input  logic Continuous_i,
  input  logic Echo_i,
  output logic Trigger_o,
  output logic Busy_o,
  output logic Done_o,
  output logic Timeout_o
);

  // state     | meaning
  // IDLE      | waiting for Start_i or Continuous_i
  // TRIG      | driving the trigger pulse
  // WAIT_RISE | waiting for the echo leading edge
  // WAIT_FALL | waiting for the echo trailing edge
  // HOLDOFF   | waiting for the measurement period to expire
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF} state_t;

  localparam int TRIG_W = (TRIG_CYCLES_P > 2) ? $clog2(TRIG_CYCLES_P) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES_P > 2) ? $clog2(TIMEOUT_CYCLES_P) : 1;
  localparam int PER_W  = ($clog2(PERIOD_CYCLES_P) > 22) ? $clog2(PERIOD_CYCLES_P) : 22;

  localparam logic [TRIG_W-1:0] TRIG_LOAD = TRIG_W'(TRIG_CYCLES_P - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES_P - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES_P - 1);
  localparam logic [PER_W-1:0]  PER_MAX   = {PER_W{1'b1}};

  state_t              state_q, state_d;
  logic [TRIG_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
  logic                trigger_q, trigger_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                echo_s1_q, echo_s1_d;
  logic                echo_s2_q, echo_s2_d;
  logic                echo_prev_q, echo_prev_d;
  logic                echo_rise, echo_fall;

  assign echo_rise = echo_s2_q & ~echo_prev_q;
  assign echo_fall = ~echo_s2_q & echo_prev_q;

  always_comb begin
    state_d     = state_q;
    trig_cnt_d  = trig_cnt_q;
    // Timeout counter saturates at zero so a late rise still times out in WAIT_FALL.
    to_cnt_d    = (to_cnt_q != '0) ? to_cnt_q - TO_W'(1) : to_cnt_q;
    per_cnt_d   = (state_q != IDLE && per_cnt_q != PER_MAX) ? per_cnt_q + PER_W'(1) : per_cnt_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    echo_s1_d   = Echo_i;
    echo_s2_d   = echo_s1_q;
    echo_prev_d = echo_s2_q;

    case (state_q)
      IDLE: begin
        if (Start_i || Continuous_i) begin
          state_d    = TRIG;
          trig_cnt_d = TRIG_LOAD;
          per_cnt_d  = '0;
        end
      end
      TRIG: begin
        if (trig_cnt_q == '0) begin
          state_d  = WAIT_RISE;
          to_cnt_d = TO_LOAD;
        end else begin
          trig_cnt_d = trig_cnt_q - TRIG_W'(1);
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d = WAIT_FALL;
        end else if (to_cnt_q == '0) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end
      end
      WAIT_FALL: begin
        if (echo_fall) begin
          state_d = HOLDOFF;
          done_d  = 1'b1;
        end else if (to_cnt_q == '0) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end
      end
      HOLDOFF: begin
        if (per_cnt_q == PER_LAST) begin
          if (Continuous_i) begin
            state_d    = TRIG;
            trig_cnt_d = TRIG_LOAD;
            per_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    trigger_d = (state_d == TRIG);
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q     <= IDLE;
      trig_cnt_q  <= '0;
      to_cnt_q    <= '0;
      per_cnt_q   <= '0;
      trigger_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      echo_s1_q   <= 1'b0;
      echo_s2_q   <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_cnt_q  <= trig_cnt_d;
      to_cnt_q    <= to_cnt_d;
      per_cnt_q   <= per_cnt_d;
      trigger_q   <= trigger_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      echo_s1_q   <= echo_s1_d;
      echo_s2_q   <= echo_s2_d;
      echo_prev_q <= echo_prev_d;
    end
  end

  assign Trigger_o = trigger_q;
  assign Busy_o    = (state_q != IDLE);
  assign Done_o    = done_q;
  assign Timeout_o = timeout_q;

endmodule

// File: tb/tb_ultrasonic_sensor_trigger.sv
// Directed bench for ultrasonic_sensor_trigger: expected trigger/done/timeout events are
// queued with their cycle numbers as stimulus is applied and popped as the DUT emits them.
module tb_ultrasonic_sensor_trigger;

  localparam int TRIG_C   = 4;
  localparam int TO_C     = 20;
  localparam int PERIOD_C = 40;

  localparam int EV_TRIG = 0;
  localparam int EV_DONE = 1;
  localparam int EV_TO   = 2;

  logic Clk_i = 1'b0;
  logic Reset_i = 1'b0;
  logic Start_i = 1'b0;
  logic Continuous_i = 1'b0;
  logic Echo_i = 1'b0;
  logic Trigger_o, Busy_o, Done_o, Timeout_o;

  ultrasonic_sensor_trigger #(
    .TRIG_CYCLES_P(TRIG_C),
    .TIMEOUT_CYCLES_P(TO_C),
    .PERIOD_CYCLES_P(PERIOD_C)
  ) dut (
    .Clk_i(Clk_i),
    .Reset_i(Reset_i),
    .Start_i(Start_i),
    .Continuous_i(Continuous_i),
    .Echo_i(Echo_i),
    .Trigger_o(Trigger_o),
    .Busy_o(Busy_o),
    .Done_o(Done_o),
    .Timeout_o(Timeout_o)
  );

  always #5 Clk_i = ~Clk_i;

  int cyc = 0;
  always @(posedge Clk_i) cyc <= cyc + 1;

  typedef struct {int kind; int cyc;} ev_t;
  ev_t exp_q[$];

  int passed = 0;
  int total = 0;
  int t0 = 0;
  int trig_w = 0;
  int exp_trig_w = TRIG_C;
  logic trig_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic push_ev(input int kind, input int rel);
    ev_t e;
    e.kind = kind;
    e.cyc  = t0 + rel;
    exp_q.push_back(e);
  endtask

  task automatic log_event(input int kind);
    ev_t e;
    chk("event_expected", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk_i);
    #1;
    if (Trigger_o && !trig_prev) begin
      log_event(EV_TRIG);
      trig_w = 0;
    end
    if (Trigger_o) trig_w++;
    if (!Trigger_o && trig_prev) chk("trigger_width", trig_w, exp_trig_w);
    if (Done_o || Timeout_o) chk("done_and_timeout_same_cycle", int'(Done_o && Timeout_o), 0);
    if (Done_o) log_event(EV_DONE);
    if (Timeout_o) log_event(EV_TO);
    trig_prev = Trigger_o;
  endtask

  // One Start_i-launched measurement with echo driven high over relative cycles [a, b].
  task automatic scn(input int a, input int b, input int res_kind, input int res_rel);
    int rel;
    tick();
    t0 = cyc;
    push_ev(EV_TRIG, 1);
    push_ev(res_kind, res_rel);
    Start_i = 1'b1;
    Echo_i  = (0 >= a && 0 <= b);
    while (cyc - t0 < PERIOD_C + 5) begin
      tick();
      rel = cyc - t0;
      Start_i = 1'b0;
      Echo_i  = (rel >= a && rel <= b);
      if (rel == PERIOD_C) chk("busy_at_period_end", int'(Busy_o), 1);
      if (rel == PERIOD_C + 1) chk("idle_after_period", int'(Busy_o), 0);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_trigger"}, int'(Trigger_o), 0);
    chk({tag, "_busy"}, int'(Busy_o), 0);
    chk({tag, "_done"}, int'(Done_o), 0);
    chk({tag, "_timeout"}, int'(Timeout_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;

    // Reset state and no auto-trigger after release.
    Reset_i = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    Reset_i = 1'b1;
    repeat (6) tick();
    chk("no_auto_trigger_busy", int'(Busy_o), 0);

    // Valid echo: rise at 12, fall detected at 20, Done_o at 21.
    scn(10, 17, EV_DONE, 21);
    // No echo: timeout 20 cycles after trigger drop (trigger low from cycle 5).
    scn(1000, -1, EV_TO, 25);
    // Echo rises and stays high.
    scn(10, 1000, EV_TO, 25);
    // Echo already high at start, drops during WAIT_RISE, never rises again.
    scn(-100, 7, EV_TO, 25);
    // Next measurement after a stuck echo behaves normally.
    scn(8, 15, EV_DONE, 19);
    // Fall detected on the last timeout cycle: edge wins.
    scn(10, 21, EV_DONE, 25);
    // Fall one cycle too late.
    scn(10, 22, EV_TO, 25);

    // Continuous mode: five periods, Start_i pulses while busy are ignored.
    tick();
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      push_ev(EV_TRIG, 1 + k * PERIOD_C);
      push_ev(EV_TO, 25 + k * PERIOD_C);
    end
    Continuous_i = 1'b1;
    Echo_i = 1'b0;
    while (cyc - t0 < 5 * PERIOD_C + 10) begin
      tick();
      rel = cyc - t0;
      Start_i = (rel == 50 || rel == 100 || rel == 130);
      Continuous_i = (rel < 170);
      if (rel == 5 * PERIOD_C) chk("cont_busy_last_period", int'(Busy_o), 1);
      if (rel == 5 * PERIOD_C + 1) chk("cont_idle_after", int'(Busy_o), 0);
    end
    Start_i = 1'b0;
    chk("cont_queue_drained", exp_q.size(), 0);

    // Reset asserted for one edge during TRIG.
    tick();
    t0 = cyc;
    push_ev(EV_TRIG, 1);
    exp_trig_w = 2;
    Start_i = 1'b1;
    while (cyc - t0 < PERIOD_C + 5) begin
      tick();
      rel = cyc - t0;
      Start_i = 1'b0;
      Reset_i = (rel != 2);
      if (rel == 2) chk("trig_before_reset", int'(Trigger_o), 1);
      if (rel == 3) chk_reset_outputs("reset_in_trig");
    end
    exp_trig_w = TRIG_C;
    chk("reset_trig_queue_drained", exp_q.size(), 0);

    // Reset asserted for one edge during WAIT_FALL.
    tick();
    t0 = cyc;
    push_ev(EV_TRIG, 1);
    Start_i = 1'b1;
    while (cyc - t0 < PERIOD_C + 5) begin
      tick();
      rel = cyc - t0;
      Start_i = 1'b0;
      Echo_i  = (rel >= 8 && rel <= 30);
      Reset_i = (rel != 15);
      if (rel == 14) chk("busy_in_wait_fall", int'(Busy_o), 1);
      if (rel == 16) chk_reset_outputs("reset_in_wait_fall");
    end
    Echo_i = 1'b0;
    chk("reset_wf_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
